// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one physical memory port between the instruction-fetch port (IF,
//   read-only) and the data-memory port (MEM, read/write). A granted request
//   is latched into request registers, issued on pmem_*, and held until
//   pmem_resp. The response is then routed back to the owner. MEM wins
//   contention. After STARVE_LIMIT consecutive MEM grants taken while IF
//   was waiting, IF is granted.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   if_memaddr/_memread/_mem_byte_enable     IF request (read only)
//   if_mem_rdata, if_mem_resp                IF response
//   mem_memaddr/_memread/_memwrite/_mem_wdata/_mem_byte_enable  MEM request
//   mem_mem_rdata, mem_mem_resp              MEM response
//   pmem_address/_read/_write/_wdata/_byte_enable  physical request
//   pmem_rdata, pmem_resp                    physical response
//   gnt_if, gnt_mem            registered state decodes (SERVE_IF / SERVE_MEM)
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] if_memaddr,
  input  logic        if_memread,
  input  logic [1:0]  if_mem_byte_enable,
  output logic [15:0] if_mem_rdata,
  output logic        if_mem_resp,
  input  logic [15:0] mem_memaddr,
  input  logic        mem_memread,
  input  logic        mem_memwrite,
  input  logic [15:0] mem_mem_wdata,
  input  logic [1:0]  mem_mem_byte_enable,
  output logic [15:0] mem_mem_rdata,
  output logic        mem_mem_resp,
  output logic [15:0] pmem_address,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [15:0] pmem_wdata,
  output logic [1:0]  pmem_byte_enable,
  input  logic [15:0] pmem_rdata,
  input  logic        pmem_resp,
  output logic        gnt_if,
  output logic        gnt_mem
);

  typedef enum logic [1:0] {IDLE, SERVE_IF, SERVE_MEM} state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic [3:0]  streak_q, streak_d;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [1:0]  be_q;
  logic        write_q;

  logic        req_if, req_mem;
  logic        grant_if, grant_mem;

  assign req_if  = if_memread;
  assign req_mem = mem_memread | mem_memwrite;

  // State and request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      streak_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      write_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      if (grant_if) begin
        addr_q  <= if_memaddr;
        be_q    <= if_mem_byte_enable;
        write_q <= 1'b0;
      end else if (grant_mem) begin
        addr_q  <= mem_memaddr;
        be_q    <= mem_mem_byte_enable;
        wdata_q <= mem_mem_wdata;
        // read+write together is treated as a write
        write_q <= mem_memwrite;
      end
    end
  end

  // Next-state, grant decision and starvation streak
  always_comb begin
    state_d   = state_q;
    streak_d  = streak_q;
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_mem && (!req_if || streak_q < LIMIT)) begin
          grant_mem = 1'b1;
          state_d   = SERVE_MEM;
          if (req_if)
            streak_d = (streak_q == 4'hF) ? streak_q : streak_q + 4'd1;
          else
            streak_d = '0;
        end else if (req_if) begin
          grant_if = 1'b1;
          state_d  = SERVE_IF;
          streak_d = '0;
        end
      end
      SERVE_IF, SERVE_MEM: begin
        if (pmem_resp)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: physical port only from latched registers while serving
  always_comb begin
    pmem_address     = '0;
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    pmem_wdata       = '0;
    pmem_byte_enable = '0;
    if_mem_rdata     = '0;
    if_mem_resp      = 1'b0;
    mem_mem_rdata    = '0;
    mem_mem_resp     = 1'b0;
    gnt_if           = 1'b0;
    gnt_mem          = 1'b0;
    if (state_q == SERVE_IF || state_q == SERVE_MEM) begin
      pmem_address     = addr_q;
      pmem_read        = ~write_q;
      pmem_write       = write_q;
      pmem_wdata       = wdata_q;
      pmem_byte_enable = be_q;
      if_mem_rdata     = pmem_rdata;
      mem_mem_rdata    = pmem_rdata;
    end
    if (state_q == SERVE_IF) begin
      gnt_if      = 1'b1;
      if_mem_resp = pmem_resp;
    end
    if (state_q == SERVE_MEM) begin
      gnt_mem      = 1'b1;
      mem_mem_resp = pmem_resp;
    end
  end

endmodule
